// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and
// a parity helper. Also intended for the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest character supported; narrower data is zero-extended, which
    // leaves the XOR parity unchanged.
    localparam int MAX_DATA_BITS = 8;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clocks-per-bit counter. Held at zero while clear is high, otherwise
// counts 0..CLKS_PER_BIT-1 and wraps; bit_done marks the last clock of a bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done = !clear && (cnt_q == LAST_CNT);

    // Next count: clear wins, wrap after the last clock of the bit.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer fed from a byte FIFO. Pops one word per
// character and sends start, LSB-first data, optional parity and stop bits.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 busy
);

    import uart_pkg::*;

    localparam logic PAR_MODE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 parity_q, parity_d;
    logic                 stop_pass_q, stop_pass_d;
    logic                 tx_q, tx_d;
    logic                 baud_clr;
    logic                 bit_done;

    // The baud counter only runs while a bit is on the line, so every
    // character starts its start bit with a fresh count.
    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clr),
        .bit_done (bit_done)
    );

    assign fifo_rd = (state_q == ST_REQ);
    assign busy    = (state_q != ST_IDLE);
    assign tx      = tx_q;

    // Next-state, datapath and line-level decode. tx is registered from the
    // current state, so the line trails the state by one clock.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        stop_pass_d = stop_pass_q;
        tx_d        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d     = fifo_data;
                parity_d    = calc_parity(MAX_DATA_BITS'(fifo_data), PAR_MODE);
                bit_idx_d   = '0;
                stop_pass_d = 1'b0;
                state_d     = ST_START;
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    // With two stop bits the counter runs one extra bit period.
                    if ((STOP_BITS == 2) && !stop_pass_q) begin
                        stop_pass_d = 1'b1;
                    end else begin
                        stop_pass_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any character in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            stop_pass_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            stop_pass_q <= stop_pass_d;
            tx_q        <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four framings driven from FIFO models, with a
// line decoder checking every serial clock against frames built from the
// popped bytes.
module tb_uart_tx_engine;

    localparam int NI = 4;

    // Instance framings: 8N1/4, 8E1/4, 8O1/4, 5O2/3.
    function automatic int cfg_cpb(input int i); return (i == 3) ? 3 : 4; endfunction
    function automatic int cfg_db(input int i);  return (i == 3) ? 5 : 8; endfunction
    function automatic int cfg_pe(input int i);  return (i == 0) ? 0 : 1; endfunction
    function automatic int cfg_po(input int i);  return (i >= 2) ? 1 : 0; endfunction
    function automatic int cfg_sb(input int i);  return (i == 3) ? 2 : 1; endfunction

    typedef struct packed {
        logic [7:0]  data;
        logic [4:0]  len;
        logic [15:0] bits;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tx_en_a    [NI];
    logic       fifo_empty_a[NI];
    logic [7:0] fifo_data_a[NI];
    logic       fifo_rd_a  [NI];
    logic       tx_a       [NI];
    logic       busy_a     [NI];

    logic [7:0] fifo_mem [NI][256];
    int         push_cnt [NI];
    int         pop_cnt  [NI];
    int         rd_cnt   [NI];
    frame_t     exp_q    [NI][$];
    bit         rd_flag  [NI];
    logic [7:0] rd_data  [NI];
    bit         prev_rd  [NI];
    bit         active   [NI];
    int         cyc      [NI];
    frame_t     cur      [NI];
    bit         b2b      [NI];
    int         gap      [NI];
    int         ferr     [NI];

    int vec_cnt = 0;
    int err_cnt = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int DB = cfg_db(gi);
            assign fifo_empty_a[gi] = (push_cnt[gi] == pop_cnt[gi]);
            uart_tx_engine #(
                .CLKS_PER_BIT (cfg_cpb(gi)),
                .DATA_BITS    (DB),
                .PARITY_EN    (cfg_pe(gi)),
                .PARITY_ODD   (cfg_po(gi)),
                .STOP_BITS    (cfg_sb(gi))
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .tx_en      (tx_en_a[gi]),
                .fifo_empty (fifo_empty_a[gi]),
                .fifo_data  (fifo_data_a[gi][DB-1:0]),
                .fifo_rd    (fifo_rd_a[gi]),
                .tx         (tx_a[gi]),
                .busy       (busy_a[gi])
            );
        end
    endgenerate

    task automatic check(input bit ok, input string name, input int inst,
                         input int act, input int exp);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s inst%0d: got %0d, expected %0d", name, inst, act, exp);
        end
    endtask

    // Expected frame from the framing rules: start 0, data LSB first,
    // parity making the count of ones even (or odd), then stop 1s.
    function automatic frame_t make_frame(input int i, input logic [7:0] b);
        frame_t f;
        int     pos;
        int     ones;
        f.bits = '1;
        f.data = b;
        pos    = 0;
        ones   = 0;
        f.bits[pos] = 1'b0;
        pos++;
        for (int j = 0; j < cfg_db(i); j++) begin
            f.bits[pos] = b[j];
            ones += int'(b[j]);
            pos++;
        end
        if (cfg_pe(i) != 0) begin
            f.bits[pos] = ((ones % 2) == 1) ^ (cfg_po(i) == 1);
            pos++;
        end
        pos += cfg_sb(i);
        f.len = 5'(pos);
        return f;
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        fifo_mem[i][push_cnt[i] % 256] = b;
        push_cnt[i]++;
    endtask

    // FIFO read data appears the clock after the strobe; garbage otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            fifo_data_a[i] <= rd_flag[i] ? rd_data[i] : 8'($urandom);
        end
    end

    // Monitor: services reads, decodes the line and scores each frame.
    always @(negedge clk) begin
        int         cpb;
        int         flen;
        int         idx;
        logic [7:0] b;
        for (int i = 0; i < NI; i++) begin
            cpb  = cfg_cpb(i);
            flen = 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
            if (!rst_n) begin
                check(tx_a[i] === 1'b1 && busy_a[i] === 1'b0 && fifo_rd_a[i] === 1'b0,
                      "reset_idle", i, int'({tx_a[i], busy_a[i], fifo_rd_a[i]}), 4);
                exp_q[i].delete();
                active[i]  = 1'b0;
                b2b[i]     = 1'b0;
                gap[i]     = 100;
                rd_flag[i] = 1'b0;
                prev_rd[i] = 1'b0;
            end else begin
                if (fifo_rd_a[i] === 1'b1) begin
                    check(!prev_rd[i] && busy_a[i] === 1'b1, "rd_pulse", i,
                          int'({prev_rd[i], busy_a[i]}), 1);
                    check(push_cnt[i] != pop_cnt[i], "underflow", i,
                          push_cnt[i] - pop_cnt[i], 1);
                    if (push_cnt[i] != pop_cnt[i]) begin
                        b = fifo_mem[i][pop_cnt[i] % 256];
                        pop_cnt[i]++;
                        exp_q[i].push_back(make_frame(i, b));
                        rd_data[i] = b;
                    end
                    rd_cnt[i]++;
                    rd_flag[i] = 1'b1;
                end else begin
                    rd_flag[i] = 1'b0;
                end
                prev_rd[i] = (fifo_rd_a[i] === 1'b1);

                if (active[i]) begin
                    idx = cyc[i] / cpb;
                    if (tx_a[i] !== cur[i].bits[idx]) ferr[i]++;
                    if (cyc[i] < flen * cpb - 1) begin
                        if (busy_a[i] !== 1'b1) ferr[i]++;
                        cyc[i]++;
                    end else begin
                        if (busy_a[i] !== 1'b0) ferr[i]++;
                        $display("inst%0d frame 0x%02h: %0d bad cycles", i, cur[i].data, ferr[i]);
                        check(ferr[i] == 0, "frame", i, ferr[i], 0);
                        b2b[i]    = (tx_en_a[i] === 1'b1) && !fifo_empty_a[i];
                        active[i] = 1'b0;
                        gap[i]    = 0;
                    end
                end else if (tx_a[i] !== 1'b1) begin
                    if (b2b[i]) check(gap[i] == 3, "b2b_gap", i, gap[i], 3);
                    else        check(gap[i] >= 3, "min_gap", i, gap[i], 3);
                    check(exp_q[i].size() != 0, "unexpected_start", i, 0, 1);
                    if (exp_q[i].size() != 0) begin
                        cur[i]    = exp_q[i].pop_front();
                        active[i] = 1'b1;
                        cyc[i]    = 1;
                        ferr[i]   = 0;
                    end
                end else if (gap[i] < 1000) begin
                    gap[i]++;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int quiet;
        int n;
        bit idle;
        quiet = 0;
        n     = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
            idle = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!fifo_empty_a[i] || busy_a[i] || active[i] || exp_q[i].size() != 0) idle = 1'b0;
            end
            quiet = idle ? quiet + 1 : 0;
        end
        check(quiet >= 4, name, 0, n, 3000);
    endtask

    // Stimulus.
    initial begin
        int r[NI];
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) tx_en_a[i] = 1'b1;
        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        push(3, 8'h07);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) check(fifo_rd_a[i] === 1'b1, "rd_after_reset", i, int'(fifo_rd_a[i]), 1);
        wait_idle("drain_first");

        // Back-to-back pair with the FIFO never empty.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h55);
            push(i, 8'hAA);
        end
        wait_idle("drain_b2b");

        // Disabled: no reads while tx_en is low.
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            tx_en_a[i] = 1'b0;
            push(i, 8'h3C);
            r[i] = rd_cnt[i];
        end
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check(rd_cnt[i] == r[i], "rd_while_disabled", i, rd_cnt[i], r[i]);

        // Enable, then drop tx_en mid-frame: frame finishes, no further read.
        for (int i = 0; i < NI; i++) tx_en_a[i] = 1'b1;
        n = 0;
        while (busy_a[0] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(n < 20, "start_wait", 0, n, 20);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            tx_en_a[i] = 1'b0;
            push(i, 8'hC3);
            r[i] = rd_cnt[i];
        end
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check(rd_cnt[i] == r[i], "rd_after_drop", i, rd_cnt[i], r[i]);
        for (int i = 0; i < NI; i++) tx_en_a[i] = 1'b1;
        wait_idle("drain_drop");

        // Randomized traffic and enable toggling.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                tx_en_a[i] = ($urandom_range(0, 7) != 0);
                if ((push_cnt[i] - pop_cnt[i]) < 6 && $urandom_range(0, 24) == 0) push(i, 8'($urandom));
            end
        end
        for (int i = 0; i < NI; i++) tx_en_a[i] = 1'b1;
        wait_idle("drain_random");

        // Reset during data bit 3 of instance 0.
        @(posedge clk);
        #1;
        push(0, 8'hA5);
        n = 0;
        while (!(active[0] && cyc[0] == 18) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(n < 500, "bit3_wait", 0, n, 500);
        check(tx_a[0] === 1'b0, "pre_rst_bit3", 0, int'(tx_a[0]), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check(tx_a[0] === 1'b1, "async_rst_tx", 0, int'(tx_a[0]), 1);
        check(busy_a[0] === 1'b0, "async_rst_busy", 0, int'(busy_a[0]), 0);
        check(fifo_rd_a[0] === 1'b0, "async_rst_rd", 0, int'(fifo_rd_a[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) r[i] = rd_cnt[i];
        repeat (60) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check(rd_cnt[i] == r[i], "rd_after_rst", i, rd_cnt[i], r[i]);
            check(tx_a[i] === 1'b1 && busy_a[i] === 1'b0, "idle_after_rst", i,
                  int'({tx_a[i], busy_a[i]}), 2);
            check(exp_q[i].size() == 0, "leftover_frames", i, exp_q[i].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
